// File: rtl/loader_pkg.sv
// Shared types and helpers for the banked memory loader.
// Holds the phase encoding and the bus-word to lane slicing used by every bank.
package loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam int MAX_BUS_W  = 1024;
   localparam int MAX_LANE_W = 64;

   // Lane 0 is the most significant lane of the word.
   function automatic logic [MAX_LANE_W-1:0] lane_of(input logic [MAX_BUS_W-1:0] word,
                                                     input int idx,
                                                     input int lane_w,
                                                     input int num_banks);
      logic [MAX_LANE_W-1:0] mask;
      mask = ~(MAX_LANE_W'(0)) >> (MAX_LANE_W - lane_w);
      return MAX_LANE_W'(word >> ((num_banks - 1 - idx) * lane_w)) & mask;
   endfunction

endpackage

// File: rtl/banked_mem_loader_bank_ram.sv
// Single-port synchronous RAM, one read cycle of latency, no reset on contents.
// Port names match the vendor RAM IP so a wrapper can drop in place of this model.
module bank_ram #(
   parameter  int DEPTH  = 16384,
   parameter  int WIDTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic [ADDR_W-1:0] address,
   input  logic              clock,
   input  logic [WIDTH-1:0]  data,
   input  logic              wren,
   output logic [WIDTH-1:0]  q
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wren) mem[address] <= data;
      q <= mem[address];
   end

endmodule

// File: rtl/banked_mem_loader.sv
// Loads bus words lane-split across NUM_BANKS RAMs, then streams them back in order.
//   state  | meaning
//   IDLE   | waiting for the first write of a layer
//   LOAD   | storing words at wr_ptr until len words are held
//   STREAM | replaying words 0..len-1 over rd_valid/rd_ready
module banked_mem_loader
   import loader_pkg::*;
#(
   parameter  int NUM_BANKS = 4,
   parameter  int LANE_W    = 8,
   parameter  int DEPTH     = 16384,
   localparam int ADDR_W    = $clog2(DEPTH),
   localparam int BUS_W     = NUM_BANKS * LANE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chipselect,
   input  logic              write,
   input  logic [BUS_W-1:0]  writedata,
   input  logic [ADDR_W:0]   cfg_len,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [BUS_W-1:0]  rd_data,
   output logic              busy,
   output logic              stream_done,
   output logic              drop_err
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

   state_t            state, state_nx;
   logic [ADDR_W:0]   wr_ptr, wr_ptr_nx;
   logic [ADDR_W:0]   rd_ptr, rd_ptr_nx;
   logic [ADDR_W:0]   len, len_nx;
   logic              rd_valid_nx, drop_err_nx;
   logic [ADDR_W:0]   cfg_len_eff;
   logic [ADDR_W-1:0] bank_addr;
   logic              bank_wren;
   logic              accept, fire;

   assign accept      = chipselect && write;
   assign fire        = rd_valid && rd_ready;
   assign busy        = (state != IDLE);
   assign cfg_len_eff = (cfg_len == '0 || cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         len      <= DEPTH_L;
         rd_valid <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         state    <= state_nx;
         wr_ptr   <= wr_ptr_nx;
         rd_ptr   <= rd_ptr_nx;
         len      <= len_nx;
         rd_valid <= rd_valid_nx;
         drop_err <= drop_err_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      wr_ptr_nx   = wr_ptr;
      rd_ptr_nx   = rd_ptr;
      len_nx      = len;
      rd_valid_nx = rd_valid;
      drop_err_nx = drop_err;
      bank_wren   = 1'b0;
      bank_addr   = '0;
      stream_done = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               len_nx    = cfg_len_eff;
               bank_wren = 1'b1;
               wr_ptr_nx = ONE;
               state_nx  = (cfg_len_eff == ONE) ? STREAM : LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               bank_wren = 1'b1;
               bank_addr = ADDR_W'(wr_ptr);
               wr_ptr_nx = wr_ptr + ONE;
               if (wr_ptr + ONE == len) state_nx = STREAM;
            end
         end
         STREAM: begin
            // Address one ahead on a handshake so the next word is ready a cycle later.
            bank_addr   = ADDR_W'(rd_ptr + (fire ? ONE : '0));
            rd_valid_nx = 1'b1;
            if (accept) drop_err_nx = 1'b1;
            if (fire) begin
               rd_ptr_nx = rd_ptr + ONE;
               if (rd_ptr == len - ONE) begin
                  stream_done = 1'b1;
                  rd_valid_nx = 1'b0;
                  rd_ptr_nx   = '0;
                  wr_ptr_nx   = '0;
                  state_nx    = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      logic [LANE_W-1:0] q_lane;

      bank_ram #(
         .DEPTH (DEPTH),
         .WIDTH (LANE_W)
      ) u_bank (
         .address (bank_addr),
         .clock   (clk),
         .data    (LANE_W'(lane_of(MAX_BUS_W'(writedata), i, LANE_W, NUM_BANKS))),
         .wren    (bank_wren),
         .q       (q_lane)
      );

      assign rd_data[BUS_W-1-i*LANE_W -: LANE_W] = q_lane;
   end

endmodule

// File: tb/tb_banked_mem_loader.sv
// Directed bench for banked_mem_loader at NUM_BANKS=4, LANE_W=8, DEPTH=16.
// Expected stream words are the hand-written load vectors, replayed in order.
module tb_banked_mem_loader;

   localparam int NUM_BANKS = 4;
   localparam int LANE_W    = 8;
   localparam int DEPTH     = 16;
   localparam int ADDR_W    = 4;
   localparam int BUS_W     = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              chipselect;
   logic              write;
   logic [BUS_W-1:0]  writedata;
   logic [ADDR_W:0]   cfg_len;
   logic              rd_valid;
   logic              rd_ready;
   logic [BUS_W-1:0]  rd_data;
   logic              busy;
   logic              stream_done;
   logic              drop_err;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   banked_mem_loader #(
      .NUM_BANKS (NUM_BANKS),
      .LANE_W    (LANE_W),
      .DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .chipselect  (chipselect),
      .write       (write),
      .writedata   (writedata),
      .cfg_len     (cfg_len),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_data     (rd_data),
      .busy        (busy),
      .stream_done (stream_done),
      .drop_err    (drop_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic wr(input logic [31:0] word);
      chipselect = 1'b1;
      write      = 1'b1;
      writedata  = word;
      step();
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic load(input logic [ADDR_W:0] len_cfg);
      cfg_len = len_cfg;
      foreach (exp_q[k]) wr(exp_q[k]);
   endtask

   // Called on the first STREAM cycle; rdy_pat/wr_pat bit c applies to cycle c.
   task automatic drain(input string tag, input int n, input logic [15:0] rdy_pat,
                        input logic [15:0] wr_pat, output int last_c);
      int idx = 0;
      int c = 0;
      logic prev_stall = 1'b0;
      last_c = -1;
      while (idx < n && c < 200) begin
         rd_ready   = (c < 16) ? rdy_pat[c] : 1'b1;
         chipselect = (c < 16) ? wr_pat[c] : 1'b0;
         write      = chipselect;
         #1;
         if (c == 0) chk({tag, "_valid_c0"}, rd_valid, 0);
         if (c == 1) chk({tag, "_valid_c1"}, rd_valid, 1);
         if (prev_stall) chk({tag, "_valid_hold"}, rd_valid, 1);
         if (rd_valid) chk({tag, "_data"}, rd_data, exp_q[idx]);
         prev_stall = rd_valid && !rd_ready;
         if (rd_valid && rd_ready) begin
            chk({tag, "_done"}, stream_done, (idx == n - 1));
            idx++;
            last_c = c;
         end else begin
            chk({tag, "_no_done"}, stream_done, 0);
         end
         @(posedge clk);
         #1;
         c++;
      end
      chipselect = 1'b0;
      write      = 1'b0;
      rd_ready   = 1'b0;
      if (idx < n) chk({tag, "_timeout_words"}, idx, n);
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_valid_after"}, rd_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int last_c;
      reset      = 1'b1;
      chipselect = 1'b0;
      write      = 1'b0;
      writedata  = '0;
      cfg_len    = '0;
      rd_ready   = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_done", stream_done, 0);
      chk("rst_drop", drop_err, 0);

      // load then stream, full throughput
      exp_q = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
      load(5'd4);
      chk("s1_busy", busy, 1);
      drain("s1", 4, 16'hFFFF, 16'h0000, last_c);
      chk("s1_last_cycle", last_c, 4);

      // backpressure 1,0,0,1,1 starting with the first valid cycle
      exp_q = '{32'hCAFEF00D, 32'h13579BDF, 32'h2468ACE0};
      load(5'd3);
      drain("s2", 3, 16'hFFF3, 16'h0000, last_c);
      chk("s2_last_cycle", last_c, 5);

      // full depth via cfg_len=0
      exp_q.delete();
      for (int k = 0; k < 16; k++) exp_q.push_back(32'h01010101 * k);
      load(5'd0);
      drain("s3a", 16, 16'hFFFF, 16'h0000, last_c);
      chk("s3a_last_cycle", last_c, 16);

      // cfg_len=20 saturates to full depth
      exp_q.delete();
      for (int k = 0; k < 16; k++) exp_q.push_back((32'h01010101 * k) ^ 32'hF0F0F0F0);
      load(5'd20);
      drain("s3b", 16, 16'hFFFF, 16'h0000, last_c);
      chk("s3b_last_cycle", last_c, 16);
      chk("s3b_drop", drop_err, 0);

      // writes during STREAM, one coincident with the final fire (cycle 3)
      exp_q = '{32'h11111111, 32'h22222222, 32'h33333333};
      load(5'd3);
      writedata = 32'hBAD0BAD0;
      drain("s4", 3, 16'hFFFF, 16'h000C, last_c);
      chk("s4_last_cycle", last_c, 3);
      chk("s4_drop", drop_err, 1);

      // len==1 loaded in the first IDLE cycle after the previous stream
      exp_q = '{32'hA5A5A5A5};
      load(5'd1);
      chk("s6_busy", busy, 1);
      drain("s6", 1, 16'hFFFF, 16'h0000, last_c);
      chk("s6_last_cycle", last_c, 1);
      chk("s6_drop_sticky", drop_err, 1);
      pulse_reset();
      chk("s6_drop_cleared", drop_err, 0);

      // reset in the middle of a load
      cfg_len = 5'd8;
      for (int k = 0; k < 5; k++) wr(32'h77000000 + k);
      chk("s5_busy_mid", busy, 1);
      pulse_reset();
      chk("s5_busy_rst", busy, 0);
      chk("s5_valid_rst", rd_valid, 0);
      exp_q = '{32'hDEADBEEF, 32'h01020304};
      load(5'd2);
      drain("s5", 2, 16'hFFFF, 16'h0000, last_c);
      chk("s5_last_cycle", last_c, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/banked_mem_loader.md
Name: banked_mem_loader

Overview:
- Parametrised successor to the 4-bank byte-lane loader used by the accelerator's Avalon-MM slave.
- Accepts bus words, splits each word into NUM_BANKS lanes, and writes lane i into bank i at a common address.
- After a configured number of words is loaded, streams the words back in order as parallel lane vectors over a valid/ready interface to the compute datapath.
- Load and stream are single-pass phases; both return to IDLE for the next layer.

Parameters:
- NUM_BANKS, 4, number of RAM banks and lanes per bus word
- LANE_W, 8, bits per lane/bank entry
- DEPTH, 16384, entries per bank
- ADDR_W, $clog2(DEPTH), bank address width (derived, not overridden)
- BUS_W, NUM_BANKS*LANE_W, bus and stream word width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe; a write is accepted when chipselect && write
- writedata  in  BUS_W  bus word; lane i = writedata[BUS_W-1-i*LANE_W -: LANE_W] (MSB lane -> bank 0)
- cfg_len  in  ADDR_W+1  words per load; sampled on the first accepted write in IDLE; 0 means DEPTH; values >DEPTH saturate to DEPTH
- rd_valid  out  1  stream word valid
- rd_ready  in  1  consumer ready
- rd_data  out  BUS_W  stream word, bank 0 in the MSB lane
- busy  out  1  high in LOAD or STREAM
- stream_done  out  1  one-cycle pulse on the final stream handshake
- drop_err  out  1  sticky; set by any write accepted in STREAM; cleared only by reset

Behaviour:
- States: IDLE, LOAD, STREAM.
- Reset: state=IDLE; wr_ptr=0, rd_ptr=0, len=DEPTH, rd_valid=0, stream_done=0, drop_err=0, busy=0. rd_data is don't-care while rd_valid=0. RAM contents are not cleared.
- Reset mid-LOAD or mid-STREAM aborts the phase immediately. The next cycle is IDLE with all outputs at reset values.
- IDLE:
  - An accepted write latches len (from cfg_len), writes all banks at address 0, sets wr_ptr=1, and moves to LOAD.
  - If len==1, go directly to STREAM instead.
- LOAD:
  - Each accepted write stores its lanes at wr_ptr in every bank (wren high that cycle only) and increments wr_ptr.
  - The write that makes wr_ptr==len moves the state to STREAM. No write is lost at this boundary.
- STREAM:
  - Bank address = rd_ptr + (fire ? 1 : 0), where fire = rd_valid && rd_ready. Banks are synchronous with 1-cycle read latency, and rd_data is the concatenated bank q.
  - rd_valid rises the cycle after entering STREAM, so first-word latency is 1 cycle from the STREAM entry edge.
  - Throughput is 1 word/cycle while rd_ready=1.
  - When stalled, address and rd_data hold and rd_valid stays high.
  - On a fire with rd_ptr==len-1: stream_done pulses, rd_valid drops the next cycle, rd_ptr and wr_ptr clear, and the state returns to IDLE.
  - An accepted write in STREAM is ignored (no RAM write) and sets drop_err.
- Simultaneous events:
  - A write and the final fire in the same cycle: the write is dropped, drop_err is set, and the state still goes to IDLE.
  - A write in the first IDLE cycle after a stream starts a new load normally.
- wr_ptr and rd_ptr are ADDR_W+1 bits and never wrap within a phase. With len=DEPTH, the last address is DEPTH-1.

Decomposition:
- Package loader_pkg:
  - state enum typedef
  - lane slicing function (word, index) -> lane
- Sub-module bank_ram: single-port synchronous RAM with ports address/clock/data/wren/q. It is generated NUM_BANKS times with a depth parameter, and a vendor IP wrapper can be substituted.

Test Plan:
Sim config is NUM_BANKS=4, LANE_W=8, DEPTH=16.
- Load then stream:
  - Stimulus: cfg_len=4; write 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; hold rd_ready=1.
  - Response: rd_data returns the same 4 words on 4 consecutive cycles; stream_done pulses with the 4th word; busy falls the next cycle.
- Backpressure:
  - Stimulus: cfg_len=3; toggle rd_ready 1,0,0,1,1.
  - Response: rd_data and rd_valid hold through the stall; exactly 3 fires in order; no duplicated or skipped words.
- Full depth:
  - Stimulus: cfg_len=0; 16 writes of values 0..15 replicated per lane.
  - Response: 16 words stream out, the last from address 15; a value of 20 behaves identically (saturates).
- Drop error:
  - Stimulus: issue a write during STREAM, including one coincident with the final fire.
  - Response: the stream data is unchanged and drop_err=1 until reset.
- Reset mid-load:
  - Stimulus: cfg_len=8; 5 writes, then assert reset for 1 cycle; new load with cfg_len=2 writing 0xDEADBEEF, 0x01020304.
  - Response: the stream yields exactly those 2 words; busy=0 and rd_valid=0 in the cycle after reset.
- len==1:
  - Stimulus: a single write of 0xA5A5A5A5.
  - Response: STREAM is entered directly; rd_valid is high on the next cycle with 0xA5A5A5A5.
